// File: rtl/count_pwm_compare.sv
// count_pwm_compare
// Consumes the free-running counter value, detects each wrap (any decrease of
// count_in), and produces a period-aligned PWM output whose duty comes from a
// double-buffered compare register. Also emits one wrap pulse per period while
// running and a sticky interrupt that only irq_clr or rst clears.
//
// Handshake: cmp_wr is a single-cycle strobe with no backpressure. Every cycle
// in which cmp_wr=1 loads cmp_data into the pending register. The pending value
// moves to the active register on the next wrap edge.

module count_pwm_compare #(
    parameter int unsigned WIDTH     = 6,
    parameter int unsigned CMP_RESET = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count_in,
    input  logic             enable,
    input  logic             cmp_wr,
    input  logic [WIDTH-1:0] cmp_data,
    input  logic             irq_clr,
    output logic             pwm_out,
    output logic             wrap_pulse,
    output logic             irq,
    output logic [WIDTH-1:0] cmp_active,
    output logic             cmp_pending_vld,
    output logic [1:0]       state_dbg
);

    localparam logic [WIDTH-1:0] CMP_RST = WIDTH'(CMP_RESET);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_prev_q, count_prev_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             pend_vld_q, pend_vld_d;
    logic [WIDTH-1:0] cmp_active_q, cmp_active_d;
    logic             pwm_q, pwm_d;
    logic             wrap_pulse_q, wrap_pulse_d;
    logic             irq_q, irq_d;
    logic             wrap;

    // A wrap is any decrease of the sampled count; increases and jumps upward never count.
    always_comb begin
        wrap = (count_in < count_prev_q);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: enable low wins; ARM waits for a wrap so RUN starts on a full period.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = ARM;
                ARM:     state_d = wrap ? RUN : ARM;
                RUN:     state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output/datapath logic: shadow register transfer, PWM compare, wrap pulse, sticky irq.
    always_comb begin
        count_prev_d = count_in;

        // New write always lands in pending; a wrap transfers the old pending value first.
        pending_d    = pending_q;
        pend_vld_d   = pend_vld_q;
        cmp_active_d = cmp_active_q;
        if (wrap && pend_vld_q) begin
            cmp_active_d = pending_q;
            pend_vld_d   = 1'b0;
        end
        if (cmp_wr) begin
            pending_d  = cmp_data;
            pend_vld_d = 1'b1;
        end

        // Compare against the value active after this edge so duty changes align to the wrap.
        pwm_d        = (state_d == RUN) && (count_in < cmp_active_d);
        wrap_pulse_d = wrap && (state_d == RUN);

        // Set beats clear when both happen on the same edge.
        irq_d = irq_q;
        if (irq_clr) begin
            irq_d = 1'b0;
        end
        if (wrap_pulse_d) begin
            irq_d = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_prev_q <= '0;
            pending_q    <= CMP_RST;
            pend_vld_q   <= 1'b0;
            cmp_active_q <= CMP_RST;
            pwm_q        <= 1'b0;
            wrap_pulse_q <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            count_prev_q <= count_prev_d;
            pending_q    <= pending_d;
            pend_vld_q   <= pend_vld_d;
            cmp_active_q <= cmp_active_d;
            pwm_q        <= pwm_d;
            wrap_pulse_q <= wrap_pulse_d;
            irq_q        <= irq_d;
        end
    end

    assign pwm_out         = pwm_q;
    assign wrap_pulse      = wrap_pulse_q;
    assign irq             = irq_q;
    assign cmp_active      = cmp_active_q;
    assign cmp_pending_vld = pend_vld_q;
    assign state_dbg       = state_q;

    // Structural invariants between the registered outputs and the state.
    a_pulse_in_run : assert property (@(posedge clk) disable iff (rst)
        wrap_pulse_q |-> (state_q == RUN));
    a_pwm_in_run : assert property (@(posedge clk) disable iff (rst)
        pwm_q |-> (state_q == RUN));
    a_pulse_sets_irq : assert property (@(posedge clk) disable iff (rst)
        wrap_pulse_q |-> irq_q);

endmodule

// File: tb/tb_count_pwm_compare.sv
// Directed bench for count_pwm_compare: the bench drives a free-running 6-bit
// count (with deliberate jumps) and checks outputs 1 ns after each rising edge.

module tb_count_pwm_compare;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] count_in;
    logic       enable;
    logic       cmp_wr;
    logic [5:0] cmp_data;
    logic       irq_clr;
    logic       pwm_out;
    logic       wrap_pulse;
    logic       irq;
    logic [5:0] cmp_active;
    logic       cmp_pending_vld;
    logic [1:0] state_dbg;

    logic [5:0] cnt;
    int         n_cmp = 0;
    int         n_err = 0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    count_pwm_compare #(.WIDTH(6), .CMP_RESET(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .count_in        (count_in),
        .enable          (enable),
        .cmp_wr          (cmp_wr),
        .cmp_data        (cmp_data),
        .irq_clr         (irq_clr),
        .pwm_out         (pwm_out),
        .wrap_pulse      (wrap_pulse),
        .irq             (irq),
        .cmp_active      (cmp_active),
        .cmp_pending_vld (cmp_pending_vld),
        .state_dbg       (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: wait for the edge, settle 1 ns, then advance the counter.
    task automatic cyc();
        @(posedge clk);
        #1;
        cnt      = cnt + 6'd1;
        count_in = cnt;
    endtask

    task automatic run_to(input logic [5:0] v);
        int n;
        n = 0;
        while (count_in != v && n < 128) begin
            cyc();
            n++;
        end
        if (count_in != v) check_eq("run_to", 32'(count_in), 32'(v));
    endtask

    task automatic write_cmp(input logic [5:0] d);
        cmp_wr   = 1'b1;
        cmp_data = d;
        cyc();
        cmp_wr   = 1'b0;
    endtask

    // Observe one full period starting with count_in==0 about to be sampled.
    task automatic measure(input bit wr_first, input logic [5:0] wdata, input bit clr_first,
                           output int highs, output int run0, output int wraps,
                           output logic wp_first, output logic irq_first);
        bit hi_run;
        highs = 0; run0 = 0; wraps = 0; hi_run = 1'b1;
        wp_first = 1'b0; irq_first = 1'b0;
        if (wr_first) begin
            cmp_wr   = 1'b1;
            cmp_data = wdata;
        end
        if (clr_first) irq_clr = 1'b1;
        for (int i = 0; i < 64; i++) begin
            cyc();
            if (i == 0) begin
                cmp_wr    = 1'b0;
                irq_clr   = 1'b0;
                wp_first  = wrap_pulse;
                irq_first = irq;
            end
            if (pwm_out) highs++;
            if (pwm_out && hi_run) run0++;
            else hi_run = 1'b0;
            if (wrap_pulse) wraps++;
        end
    endtask

    initial begin
        int   highs, run0, wraps;
        logic wp0, irq0;

        rst = 1'b1; enable = 1'b0; cmp_wr = 1'b0; cmp_data = '0; irq_clr = 1'b0;
        cnt = '0; count_in = '0;

        // 1. Reset with counter running, then enable and align to a full period.
        repeat (5) cyc();
        check_eq("rst_pwm", 32'(pwm_out), 0);
        check_eq("rst_wrap", 32'(wrap_pulse), 0);
        check_eq("rst_irq", 32'(irq), 0);
        check_eq("rst_vld", 32'(cmp_pending_vld), 0);
        check_eq("rst_active", 32'(cmp_active), 32);
        check_eq("rst_state", 32'(state_dbg), 32'(S_IDLE));
        rst = 1'b0; enable = 1'b1;
        cyc();
        check_eq("t1_arm", 32'(state_dbg), 32'(S_ARM));
        check_eq("t1_arm_wrap", 32'(wrap_pulse), 0);
        run_to(6'd0);
        check_eq("t1_still_arm", 32'(state_dbg), 32'(S_ARM));
        check_eq("t1_arm_pwm", 32'(pwm_out), 0);
        measure(0, 6'd0, 0, highs, run0, wraps, wp0, irq0);
        check_eq("t1_wp_first", 32'(wp0), 1);
        check_eq("t1_irq_first", 32'(irq0), 1);
        check_eq("t1_highs", 32'(highs), 32);
        check_eq("t1_run0", 32'(run0), 32);
        check_eq("t1_wraps", 32'(wraps), 1);
        check_eq("t1_run", 32'(state_dbg), 32'(S_RUN));

        // 2. Mid-period write of 10 waits for the wrap.
        run_to(6'd20);
        write_cmp(6'd10);
        check_eq("t2_vld", 32'(cmp_pending_vld), 1);
        check_eq("t2_active_hold", 32'(cmp_active), 32);
        run_to(6'd0);
        measure(0, 6'd0, 0, highs, run0, wraps, wp0, irq0);
        check_eq("t2_highs", 32'(highs), 10);
        check_eq("t2_run0", 32'(run0), 10);
        check_eq("t2_vld_clr", 32'(cmp_pending_vld), 0);
        check_eq("t2_active", 32'(cmp_active), 10);

        // 3. Write 7, then back-to-back 40/10 (last wins), then 5 on the wrap edge.
        run_to(6'd30);
        write_cmp(6'd7);
        run_to(6'd0);
        measure(0, 6'd0, 0, highs, run0, wraps, wp0, irq0);
        check_eq("t3_highs7", 32'(highs), 7);
        run_to(6'd30);
        write_cmp(6'd40);
        write_cmp(6'd10);
        run_to(6'd0);
        measure(1, 6'd5, 0, highs, run0, wraps, wp0, irq0);
        check_eq("t3_highs10", 32'(highs), 10);
        check_eq("t3_vld_kept", 32'(cmp_pending_vld), 1);
        check_eq("t3_active10", 32'(cmp_active), 10);
        measure(0, 6'd0, 0, highs, run0, wraps, wp0, irq0);
        check_eq("t3_highs5", 32'(highs), 5);
        check_eq("t3_vld_clr", 32'(cmp_pending_vld), 0);
        check_eq("t3_active5", 32'(cmp_active), 5);

        // 4. Boundary duties 0 and 63.
        run_to(6'd30);
        write_cmp(6'd0);
        run_to(6'd0);
        measure(0, 6'd0, 0, highs, run0, wraps, wp0, irq0);
        check_eq("t4_highs0", 32'(highs), 0);
        check_eq("t4_wraps0", 32'(wraps), 1);
        run_to(6'd30);
        write_cmp(6'd63);
        run_to(6'd0);
        measure(0, 6'd0, 0, highs, run0, wraps, wp0, irq0);
        check_eq("t4_highs63", 32'(highs), 63);
        check_eq("t4_run63", 32'(run0), 63);

        // 5. irq set-wins, plain clear, enable drop.
        measure(0, 6'd0, 1, highs, run0, wraps, wp0, irq0);
        check_eq("t5_irq_setwins", 32'(irq0), 1);
        run_to(6'd10);
        irq_clr = 1'b1;
        cyc();
        irq_clr = 1'b0;
        check_eq("t5_irq_clr", 32'(irq), 0);
        run_to(6'd0);
        cyc();
        check_eq("t5_irq_reset", 32'(irq), 1);
        run_to(6'd20);
        check_eq("t5_pwm_hi", 32'(pwm_out), 1);
        enable = 1'b0;
        cyc();
        check_eq("t5_dis_pwm", 32'(pwm_out), 0);
        check_eq("t5_dis_wrap", 32'(wrap_pulse), 0);
        check_eq("t5_dis_irq", 32'(irq), 1);
        check_eq("t5_dis_state", 32'(state_dbg), 32'(S_IDLE));

        // Shadow transfer still happens on a wrap in IDLE.
        write_cmp(6'd15);
        run_to(6'd0);
        cyc();
        check_eq("t5_idle_active", 32'(cmp_active), 15);
        check_eq("t5_idle_vld", 32'(cmp_pending_vld), 0);
        check_eq("t5_idle_wrap", 32'(wrap_pulse), 0);

        // 6. Async reset pulse mid-cycle in RUN at count 40.
        enable = 1'b1;
        cyc();
        run_to(6'd0);
        cyc();
        check_eq("t6_run", 32'(state_dbg), 32'(S_RUN));
        run_to(6'd35);
        write_cmp(6'd50);
        run_to(6'd40);
        check_eq("t6_pre_vld", 32'(cmp_pending_vld), 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6_rst_irq", 32'(irq), 0);
        check_eq("t6_rst_vld", 32'(cmp_pending_vld), 0);
        check_eq("t6_rst_active", 32'(cmp_active), 32);
        check_eq("t6_rst_state", 32'(state_dbg), 32'(S_IDLE));
        #2;
        rst = 1'b0;
        cyc();
        check_eq("t6_arm", 32'(state_dbg), 32'(S_ARM));
        check_eq("t6_nowrap", 32'(wrap_pulse), 0);
        cnt = 6'd60; count_in = cnt;
        cyc();
        check_eq("t6_jump_up_wrap", 32'(wrap_pulse), 0);
        check_eq("t6_jump_up_state", 32'(state_dbg), 32'(S_ARM));
        cnt = 6'd3; count_in = cnt;
        cyc();
        check_eq("t6_drop_wrap", 32'(wrap_pulse), 1);
        check_eq("t6_drop_state", 32'(state_dbg), 32'(S_RUN));
        check_eq("t6_drop_pwm", 32'(pwm_out), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
